// File: rtl/tick_meter_pkg.sv
// tick_meter_pkg: shared types and default constants for the tick period meter.
//   meter_state_t   - measurement FSM states
//   DEF_CNT_W       - default counter/output width
//   DEF_TIMEOUT     - default abort limit in clk cycles
//   DEF_SYNC_STAGES - default synchronizer depth
package tick_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        HOLD = 2'd3
    } meter_state_t;

    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_TIMEOUT     = 100000000;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/tick_period_meter_if.sv
// tick_period_meter_if: request/result bundle of the tick period meter.
//   start     - single-cycle request to begin one measurement
//   ready     - consumer accepts the current result
//   valid     - result available, held until accepted
//   period    - measured period in clk cycles
//   high_time - clk cycles the input was high within the period
//   timeout   - result is an aborted measurement
//   busy      - meter is not idle
// Modports: master = consumer side, slave = meter side.
interface tick_period_meter_if import tick_meter_pkg::*; #(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             start;
    logic             ready;
    logic             valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             timeout;
    logic             busy;

    modport master (
        output start,
        output ready,
        input  valid,
        input  period,
        input  high_time,
        input  timeout,
        input  busy
    );

    modport slave (
        input  start,
        input  ready,
        output valid,
        output period,
        output high_time,
        output timeout,
        output busy
    );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronizes an asynchronous level and flags its rising edges.
//   clk_i      - system clock
//   reset_i    - synchronous active-high reset
//   async_in_i - asynchronous input
//   lvl_o      - synchronized level (SYNC_STAGES flops deep)
//   rise_o     - one-cycle pulse when lvl_o goes 0 -> 1
module sync_edge_det import tick_meter_pkg::*; #(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_in_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in_i};
            lvl_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = lvl_o & ~lvl_prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the period (and optionally the high time) of a slow
// asynchronous tick in system clock cycles, one measurement per start request.
//   clk_i    - system clock
//   reset_i  - synchronous active-high reset
//   sig_in_i - asynchronous tick to measure
//   meter_io - request/result bundle (slave side)
// Build option: define TICK_METER_DUTY_EN to implement the high-time counter;
// otherwise high_time is tied to 0.
module tick_period_meter import tick_meter_pkg::*; #(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                sig_in_i,
    tick_period_meter_if.slave  meter_io
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    logic rise;
`ifdef TICK_METER_DUTY_EN
    logic lvl;
`endif

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .async_in_i (sig_in_i),
`ifdef TICK_METER_DUTY_EN
        .lvl_o      (lvl),
`else
        .lvl_o      (),
`endif
        .rise_o     (rise)
    );

    meter_state_t     state_q, state_d;
    // Shared counter: wait count in ARM, period count in MEAS.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             timeout_q, timeout_d;
`ifdef TICK_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        timeout_d = timeout_q;
`ifdef TICK_METER_DUTY_EN
        hcnt_d    = hcnt_q;
        high_d    = high_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (meter_io.start) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    // Opening-edge cycle counts toward the period and is high.
                    state_d = MEAS;
                    cnt_d   = CNT_W'(1);
`ifdef TICK_METER_DUTY_EN
                    hcnt_d  = CNT_W'(1);
`endif
                end else if (cnt_q == TimeoutVal) begin
                    state_d   = HOLD;
                    timeout_d = 1'b1;
                    period_d  = '0;
`ifdef TICK_METER_DUTY_EN
                    high_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEAS: begin
                if (rise) begin
                    // Closing-edge cycle belongs to the next period.
                    state_d   = HOLD;
                    timeout_d = 1'b0;
                    period_d  = cnt_q;
`ifdef TICK_METER_DUTY_EN
                    high_d    = hcnt_q;
`endif
                end else if (cnt_q == TimeoutVal) begin
                    state_d   = HOLD;
                    timeout_d = 1'b1;
                    period_d  = '0;
`ifdef TICK_METER_DUTY_EN
                    high_d    = '0;
`endif
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
`ifdef TICK_METER_DUTY_EN
                    hcnt_d = hcnt_q + CNT_W'(lvl);
`endif
                end
            end
            HOLD: begin
                if (meter_io.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
`ifdef TICK_METER_DUTY_EN
            hcnt_q    <= '0;
            high_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
`ifdef TICK_METER_DUTY_EN
            hcnt_q    <= hcnt_d;
            high_q    <= high_d;
`endif
        end
    end

    assign meter_io.valid     = (state_q == HOLD);
    assign meter_io.busy      = (state_q != IDLE);
    assign meter_io.period    = period_q;
    assign meter_io.timeout   = timeout_q;
`ifdef TICK_METER_DUTY_EN
    assign meter_io.high_time = high_q;
`else
    assign meter_io.high_time = '0;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: directed self-checking bench for tick_period_meter.
// Expected high_time follows the TICK_METER_DUTY_EN build option.
module tb_tick_period_meter;
    import tick_meter_pkg::*;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned TIMEOUT     = 64;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef TICK_METER_DUTY_EN
    localparam bit DutyEn = 1'b1;
`else
    localparam bit DutyEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic sig_in;

    tick_period_meter_if #(.CNT_W(CNT_W)) bus ();

    tick_period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .sig_in_i (sig_in),
        .meter_io (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Tick generator, driven on the falling edge.
    bit wave_en   = 1'b0;
    bit const_val = 1'b0;
    int hi_len    = 5;
    int lo_len    = 5;

    initial begin
        sig_in = 1'b0;
        forever begin
            if (wave_en) begin
                sig_in = 1'b1;
                repeat (hi_len) @(negedge clk);
                sig_in = 1'b0;
                repeat (lo_len) @(negedge clk);
            end else begin
                sig_in = const_val;
                @(negedge clk);
            end
        end
    end

    task automatic check(input string tag, input logic [CNT_W-1:0] obs,
                         input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!bus.valid && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept();
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic set_wave(input int h, input int l);
        hi_len  = h;
        lo_len  = l;
        wave_en = 1'b1;
        tick(3 * (h + l) + 10);
    endtask

    task automatic set_const(input bit v);
        const_val = v;
        wave_en   = 1'b0;
        tick(60);
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.ready = 1'b0;
        tick(3);
        check("rst_valid",   bus.valid,     0);
        check("rst_busy",    bus.busy,      0);
        check("rst_period",  bus.period,    0);
        check("rst_high",    bus.high_time, 0);
        check("rst_timeout", bus.timeout,   0);
        reset = 1'b0;

        // 5 high / 5 low
        set_wave(5, 5);
        pulse_start();
        check("w55_busy_arm", bus.busy, 1);
        wait_valid(100, n);
        check("w55_valid",   bus.valid,     1);
        check("w55_period",  bus.period,    10);
        check("w55_high",    bus.high_time, DutyEn ? 5 : 0);
        check("w55_timeout", bus.timeout,   0);
        check("w55_busy",    bus.busy,      1);

        // Hold with ready low; a start pulse inside the window is ignored.
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 8);
            tick(1);
            check("hold_valid",  bus.valid,     1);
            check("hold_period", bus.period,    10);
            check("hold_high",   bus.high_time, DutyEn ? 5 : 0);
        end
        bus.start = 1'b0;
        accept();
        check("acc_valid",  bus.valid,  0);
        check("acc_busy",   bus.busy,   0);
        check("acc_period", bus.period, 10);
        tick(1);
        check("acc_noqueue_busy", bus.busy, 0);

        // 3 high / 7 low; release with start and ready together.
        set_wave(3, 7);
        pulse_start();
        wait_valid(100, n);
        check("w37_valid",   bus.valid,     1);
        check("w37_period",  bus.period,    10);
        check("w37_high",    bus.high_time, DutyEn ? 3 : 0);
        check("w37_timeout", bus.timeout,   0);
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.ready = 1'b0;
        check("sr_valid", bus.valid, 0);
        check("sr_busy",  bus.busy,  0);
        tick(1);
        check("sr_dropped_busy", bus.busy, 0);

        // Minimum period, back to back with ready in the valid cycle.
        set_wave(1, 1);
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_valid(50, n);
            check("p2_valid",   bus.valid,     1);
            check("p2_period",  bus.period,    2);
            check("p2_high",    bus.high_time, DutyEn ? 1 : 0);
            check("p2_timeout", bus.timeout,   0);
            accept();
            check("p2_acc_valid", bus.valid, 0);
            pulse_start();
        end
        wait_valid(50, n);
        accept();

        // Reset in the middle of a measurement.
        set_wave(20, 20);
        pulse_start();
        n = 0;
        while (dut.state_q != MEAS && n < 100) begin
            tick(1);
            n++;
        end
        check("mid_reached_meas", (dut.state_q == MEAS), 1);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mr_valid",   bus.valid,     0);
        check("mr_busy",    bus.busy,      0);
        check("mr_period",  bus.period,    0);
        check("mr_high",    bus.high_time, 0);
        check("mr_timeout", bus.timeout,   0);

        set_wave(2, 2);
        pulse_start();
        wait_valid(50, n);
        check("w22_valid",  bus.valid,     1);
        check("w22_period", bus.period,    4);
        check("w22_high",   bus.high_time, DutyEn ? 2 : 0);
        accept();

        // Stuck low then stuck high: timeout after TIMEOUT+1 cycles.
        for (int s = 0; s < 2; s++) begin
            set_const(s[0]);
            pulse_start();
            wait_valid(200, n);
            check("to_latency", n,             65);
            check("to_valid",   bus.valid,     1);
            check("to_timeout", bus.timeout,   1);
            check("to_period",  bus.period,    0);
            check("to_high",    bus.high_time, 0);
            accept();
            check("to_acc_busy", bus.busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Measures an incoming slow clock/tick (e.g. the 1 Hz stopwatch tick) against the fast system clock.
- It is the receiving end of the clock-divider path: the divider turns a cycle count into a slow clock; this block turns a slow clock back into a cycle count (period, plus optional high time).
- Used for self-check of divider outputs and for on-board display of the measured tick rate.

Parameters:
- CNT_W, 32, width of the period/high-time counters and outputs.
- TIMEOUT, 100000000, cycles without the expected edge before a measurement is aborted; must be < 2**CNT_W.
- SYNC_STAGES, 2, flip-flop stages synchronizing sig_in; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous slow clock/tick to measure.
- start  in  1  single-cycle request to begin one measurement.
- ready  in  1  consumer accepts the current result.
- valid  out  1  result available; held until accepted.
- period  out  CNT_W  measured period in clk cycles.
- high_time  out  CNT_W  clk cycles sig_in was high within the period.
- timeout  out  1  result is an aborted measurement.
- busy  out  1  block is not in IDLE.

Behaviour:
- Reset:
  - one clock, one synchronous active-high reset; all state updates on posedge clk only.
  - reset=1 at a clk edge forces IDLE; valid, period, high_time, timeout, busy, counters and synchronizer flops all go to 0.
  - Reset has priority over every other input, including mid-measurement and during HOLD.
- Front end:
  - sig_in passes through SYNC_STAGES flops to give lvl, then a registered previous value.
  - rise = lvl & ~lvl_prev.
  - Front-end latency is constant, so measured values are unaffected.
- FSM (IDLE, ARM, MEAS, HOLD):
  - IDLE: busy=0. start=1 -> ARM; wait counter cleared.
  - ARM: waits for the opening rise.
    - rise -> MEAS; cnt<=1, hcnt<=1 (the opening-edge cycle counts and is high).
    - Otherwise wait++. wait reaching TIMEOUT -> HOLD with timeout=1, period=0, high_time=0.
  - MEAS:
    - Non-rise cycle: cnt++ and hcnt+=lvl.
    - rise (closing edge): period<=cnt, high_time<=hcnt, timeout<=0 -> HOLD. The closing-edge cycle is excluded.
    - cnt reaching TIMEOUT before a rise -> HOLD with timeout=1, period=0, high_time=0.
  - HOLD: valid=1, outputs stable. ready=1 -> IDLE with valid=0 on the next cycle. period, high_time and timeout keep their last values until the next result loads.
- Handshake:
  - valid rises the cycle after the closing edge or timeout is detected.
  - Transfer happens when valid & ready are both 1 at a clk edge. ready while valid=0 is ignored.
- start outside IDLE is ignored (not queued). start and ready in the same HOLD cycle: ready is honoured, start is dropped.
- Boundaries:
  - sig_in stuck high or stuck low -> timeout.
  - Minimum measurable period is 2 (1 high/1 low), giving period=2, high_time=1.
  - Counters never wrap because TIMEOUT < 2**CNT_W.

Optional Feature:
- Macro TICK_METER_DUTY_EN.
- Defined: hcnt is implemented and high_time reports as above.
- Undefined: hcnt is removed and high_time is tied to 0. period, timeout and the handshake are unchanged.

Decomposition:
- Package tick_meter_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARM, MEAS, HOLD} meter_state_t;
  - default constants DEF_CNT_W=32, DEF_TIMEOUT=100000000, DEF_SYNC_STAGES=2.
- Sub-module sync_edge_det (parameter SYNC_STAGES; ports clk, reset, async_in, lvl, rise) holds the synchronizer chain and the rising-edge detector.
- The FSM and counters stay in tick_period_meter.

Test Plan:
- Reset, then start; sig_in square wave 5 high/5 low -> valid=1, period=10, high_time=5 (DUTY_EN defined), timeout=0, busy=1 until ready.
- sig_in 3 high/7 low with TICK_METER_DUTY_EN defined -> period=10, high_time=3. Same stimulus with the macro undefined -> period=10, high_time=0.
- TIMEOUT=64, sig_in held 0, start -> valid rises 65 cycles after start with timeout=1, period=0. Repeat with sig_in held 1 -> same result.
- After a result, ready held low 20 cycles with a start pulse inside that window -> valid, period and high_time stay stable and start is ignored. ready=1 for one cycle -> valid=0 and busy=0 on the next cycle.
- reset pulsed for one cycle mid-MEAS -> all outputs 0 and FSM in IDLE the next cycle. A new start on a 4-cycle (2/2) wave then yields period=4, high_time=2.
- sig_in toggling every cycle (period 2) -> period=2, high_time=1. Back-to-back measurements with ready asserted in the valid cycle return identical results.
